data_rr_arbiter: RTL
====================

Name: data_rr_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit data output channel between NR_PORTS requesters. Transfers use a valid/ready handshake with a last marker, so a grant is held for a whole burst. The output is registered and feeds a single downstream consumer, for example a `module7` instance.

Parameters:
WIDTH, 32, data width of every port and of the output
NR_PORTS, 4, number of requesters (2..16)
TIMEOUT, 255, stall-cycle limit for the watchdog (only used with ARB_WATCHDOG_EN)

Ports:
clk_i  input  1  clock; all logic is rising-edge
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  NR_PORTS  per-port beat valid
req_data_i  input  NR_PORTS*WIDTH  packed data; port k occupies bits [k*WIDTH +: WIDTH]
req_last_i  input  NR_PORTS  per-port last beat of burst
req_ready_o  output  NR_PORTS  per-port beat accepted
data_o  output  WIDTH  registered output data
valid_o  output  1  output beat valid
last_o  output  1  output last marker
ready_i  input  1  downstream ready
grant_o  output  NR_PORTS  one-hot current owner; 0 when IDLE
busy_o  output  1  high while in LOCKED
error_o  output  1  watchdog pulse; tied 0 when the feature is compiled out

Behaviour:
- Reset values, async on rst_ni low: data_o = 0, valid_o = 0, last_o = 0, grant_o = 0, busy_o = 0, error_o = 0. Round-robin pointer = 0. State = IDLE.
- Output stage:
  - The stage is free when valid_o == 0 or ready_i == 1.
  - req_ready_o[k] = grant_o[k] AND stage free. This is combinational, with no dependency on req_valid_i.
- Accepted beat:
  - A beat is accepted when req_valid_i[k] AND req_ready_o[k].
  - On an accepted beat, data_o, last_o and valid_o (=1) load in the next cycle. Latency from an accepted input beat to valid_o is 1 cycle.
  - If the stage is free and no beat is accepted, valid_o clears.
- State IDLE:
  - Each cycle, scan req_valid_i starting at port pointer and wrapping past NR_PORTS-1 to 0.
  - The first valid port wins. grant_o is set next cycle, state moves to LOCKED, busy_o = 1.
  - No valid request: stay IDLE.
  - Arbitration costs one bubble cycle per burst.
- State LOCKED:
  - The grant holds until the owner's beat with req_last_i = 1 is accepted.
  - On that cycle: pointer = owner + 1 (wraps to 0 after NR_PORTS-1), grant_o = 0, state goes to IDLE next cycle.
  - Requests from other ports are ignored while LOCKED.
- Single-beat burst: valid with last = 1 on the first beat. The grant lasts exactly 1 handshake cycle.
- Fairness: with all ports requesting continuously, grants rotate 0,1,2,...,NR_PORTS-1,0,...
- Owner drops req_valid_i mid-burst: the grant is kept and no beat is transferred. With the watchdog compiled out, the lock lasts indefinitely.
- Downstream stall (ready_i = 0 with valid_o = 1): data_o and last_o are stable, and req_ready_o stays 0 for every port.
- Reset asserted mid-burst: everything returns to reset values immediately. The partial burst is dropped, with no recovery.
- data_o holds its last value when valid_o = 0. Downstream must qualify data with valid_o.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- With the macro defined:
  - An 8..16-bit counter, sized for TIMEOUT, counts LOCKED cycles in which the owner has req_valid_i = 0.
  - The counter clears on any accepted beat.
  - When the count reaches TIMEOUT: error_o pulses high for 1 cycle, the grant is released, the pointer advances past the owner, and state goes to IDLE. No last_o is emitted for the truncated burst.
- Without the macro: no counter is built, error_o is tied 0, and the lock is unbounded.

Test Plan:
- Reset, then port 2 sends 3 beats A,B,C with last on C, ready_i = 1 -> grant_o = 4'b0100 one cycle after the request; data_o = A,B,C on consecutive cycles with last_o on C; grant_o = 0 and busy_o = 0 after C.
- All 4 ports request single-beat bursts continuously -> grant_o sequence 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
- Port 0 mid-burst and ready_i held 0 for 5 cycles -> data_o stable, req_ready_o = 0 throughout; the next beat follows 1 cycle after ready_i returns to 1.
- Port 1 locked while port 3 requests -> port 3 is not granted until port 1's last beat is accepted; the pointer then makes port 3 the next grant ahead of port 0.
- rst_ni pulled low while port 0 is mid-burst -> all outputs are 0 at once; after release, a new request from port 0 is granted normally.
- With ARB_WATCHDOG_EN and TIMEOUT = 4, the owner drops valid for 4 cycles -> error_o pulses once, the grant is released, and the next requester is granted.

Source files
------------

// File: rtl/data_rr_arbiter.sv
// Round-robin burst arbiter sharing one registered valid/ready output channel.
// Optional stall watchdog: define ARB_WATCHDOG_EN.
module data_rr_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NR_PORTS = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NR_PORTS-1:0]       req_valid_i,
  input  logic [NR_PORTS*WIDTH-1:0] req_data_i,
  input  logic [NR_PORTS-1:0]       req_last_i,
  output logic [NR_PORTS-1:0]       req_ready_o,
  output logic [WIDTH-1:0]          data_o,
  output logic                      valid_o,
  output logic                      last_o,
  input  logic                      ready_i,
  output logic [NR_PORTS-1:0]       grant_o,
  output logic                      busy_o,
  output logic                      error_o
);

  localparam int unsigned PW = $clog2(NR_PORTS);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       own_q, own_d;
  logic [NR_PORTS-1:0] grant_q, grant_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                err_q, err_d;

  logic             free;
  logic             acc;
  logic             own_last;
  logic [WIDTH-1:0] own_data;
  logic [PW-1:0]    own_nxt;
  logic [PW-1:0]    win;
  logic             found;
  logic             wd_fire;

  assign free        = !valid_q || ready_i;
  assign req_ready_o = free ? grant_q : '0;
  assign acc         = |(req_valid_i & req_ready_o);
  assign own_last    = req_last_i[own_q];
  assign own_data    = req_data_i[own_q*WIDTH +: WIDTH];
  assign own_nxt     = (own_q == PW'(NR_PORTS-1))
                     ? '0 : own_q + 1'b1;

  // first valid port at or after ptr_q, wrapping
  always_comb begin : scan
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NR_PORTS) idx = idx - NR_PORTS;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned CR = $clog2(TIMEOUT+1);
  localparam int unsigned CW = (CR < 8) ? 8 :
                               (CR > 16) ? 16 : CR;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          own_valid;

  assign own_valid = req_valid_i[own_q];

  always_comb begin
    cnt_d   = cnt_q;
    wd_fire = 1'b0;
    if (state_q != LOCKED || acc) begin
      cnt_d = '0;
    end else if (!own_valid) begin
      cnt_d   = cnt_q + 1'b1;
      wd_fire = (cnt_d == CW'(TIMEOUT));
      if (wd_fire) cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign error_o = err_q;
`else
  assign wd_fire = 1'b0;
  assign error_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    if (acc) begin
      data_d  = own_data;
      last_d  = own_last;
      valid_d = 1'b1;
    end else if (free) begin
      valid_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = LOCKED;
          own_d        = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
        end
      end
      LOCKED: begin
        if ((acc && own_last) || wd_fire) begin
          state_d = IDLE;
          ptr_d   = own_nxt;
          grant_d = '0;
          err_d   = wd_fire;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q == LOCKED);

endmodule
